mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  EX/MEM pipeline register plus data-SRAM access stage of the 5-stage MIPS core. Consumes the
//  execute stage's ALU result/address, forwarded store data, destination register and exception
//  record; issues data_sram requests; aligns and extends load data; raises AdEL/AdES.
//  Feeds result_mem and Exc_mem back to execute for forwarding and younger-exception masking.
// PARAMETERS
//  ADEL_CODE  5'h04          ExcCode for a misaligned load.
//  ADES_CODE  5'h05          ExcCode for a misaligned store.
//  ADDR_MASK  32'hFFFF_FFFF  AND-mask applied to data_sram_addr (kseg translation hook).
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous reset, active high
//  stall            in   1   hold M register, block new SRAM request
//  flush            in   1   load bubble into M register (wins over stall)
//  PC_in            in   32  EX-stage PC
//  result_in        in   32  ALU result / effective address
//  D_in             in   32  forwarded rt (store data)
//  rw_in            in   5   destination register
//  RegWrite_in      in   1   EX instruction writes GPR
//  MemRead_in       in   1   load
//  MemWrite_in      in   1   store
//  MemOp_in         in   3   000 B, 001 BU, 010 H, 011 HU, 100 W (stores use 000/010/100)
//  Exc_in           in   1   exception already raised upstream
//  BadVAddr_in      in   32  upstream BadVAddr
//  Status_in        in   32  upstream Status image
//  Cause_in         in   31  upstream Cause image
//  data_sram_en     out  1   SRAM request, combinational from EX-side inputs
//  data_sram_wen    out  4   byte write enables
//  data_sram_addr   out  32  {result_in[31:2],2'b00} & ADDR_MASK
//  data_sram_wdata  out  32  replicated store data
//  data_sram_rdata  in   32  read data, valid the cycle after an enabled read
//  PC_out           out  32  registered PC
//  result_mem       out  32  registered result_in (forwarding path to execute)
//  rw_out           out  5   registered destination
//  RegWrite_out     out  1   registered write enable, forced 0 when Exc_mem
//  dataW            out  32  writeback value: formatted load data if load, else result_mem
//  Exc_mem          out  1   registered exception flag
//  BadVAddr_out / Status_out / Cause_out  out  32/32/31  registered exception record
// BEHAVIOUR
//  - Reset: every registered output and the load-hold flag/register = 0; dataW = 0.
//  - Alignment error: H/HU/SH with addr[0]=1, W/SW with addr[1:0]!=0. B never faults.
//  - EX-side exception record: Exc_in passes through unchanged (priority); else alignment error
//    gives Exc=1, BadVAddr=result_in, Status={9'b0,1'b1,20'b0,1'b1,1'b0}, Cause={24'b0,code,2'b0};
//    else all zero.
//  - data_sram_en = (MemRead_in|MemWrite_in) & !align_err & !Exc_in & !Exc_mem & !stall & !flush.
//  - Stores: SB wen=4'b0001<<addr[1:0], wdata={4{D_in[7:0]}}; SH wen=addr[1]?1100:0011,
//    wdata={2{D_in[15:0]}}; SW wen=1111, wdata=D_in. wen=0 whenever en=0 or load.
//  - M register update on posedge: flush -> bubble (RegWrite,MemRead,Exc,rw all 0); else stall
//    -> hold; else capture EX-side values. Latency EX->M one cycle.
//  - Load formatting in M uses registered addr[1:0] and MemOp: byte lane = addr[1:0], half
//    lane = addr[1]; B/H sign-extend, BU/HU zero-extend, W direct.
//  - Load hold: first cycle M holds a load with stall=1, formatted rdata is captured and hold
//    flag set; dataW uses held value while flag set; flag clears when M advances or flushes.
//  - Exc_mem=1 suppresses any new SRAM request (no store after an excepting older instruction).
//  - Reset mid-access: outstanding read data is discarded; no write issued during rst=1.
// TESTING
//  - SW addr 0x1000, D=0xDEADBEEF -> en=1, wen=1111, wdata=0xDEADBEEF; next cycle result_mem=0x1000.
//  - SB addr 0x1003, D=0x000000A5 -> wen=1000, wdata=0xA5A5A5A5; LB same addr, rdata=0xA5000000 -> dataW=0xFFFFFFA5.
//  - LHU addr 0x2002, rdata=0x8001_1234 -> dataW=0x00008001; LH -> 0xFFFF8001.
//  - LW addr 0x3001 -> en=0, next cycle Exc_mem=1, BadVAddr_out=0x3001, Cause_out[6:2]=4, RegWrite_out=0.
//  - Load in M then stall 3 cycles with rdata changing to garbage -> dataW stays at captured value.
//  - flush and stall together with valid SW in EX -> en=0, M becomes bubble, no write issued.

Source files
------------

// File: rtl/mem_stage.sv
// EX/MEM pipeline register and data-SRAM access stage: issues SRAM requests, raises AdEL/AdES,
// and aligns/extends load data for writeback, with a hold register for stalled loads.
module mem_stage #(
  parameter logic [4:0]  ADEL_CODE = 5'h04,
  parameter logic [4:0]  ADES_CODE = 5'h05,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] PC_in,
  input  logic [31:0] result_in,
  input  logic [31:0] D_in,
  input  logic [4:0]  rw_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  MemOp_in,
  input  logic        Exc_in,
  input  logic [31:0] BadVAddr_in,
  input  logic [31:0] Status_in,
  input  logic [30:0] Cause_in,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] result_mem,
  output logic [4:0]  rw_out,
  output logic        RegWrite_out,
  output logic [31:0] dataW,
  output logic        Exc_mem,
  output logic [31:0] BadVAddr_out,
  output logic [31:0] Status_out,
  output logic [30:0] Cause_out
);

  localparam logic [31:0] EXC_STATUS = {9'b0, 1'b1, 20'b0, 1'b1, 1'b0};

  // Byte/half lane selection and sign/zero extension of raw SRAM read data.
  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [2:0] op,
                                           input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*lo +: 8];
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {24'b0, b};
      3'b010:  fmt_load = {{16{h[15]}}, h};
      3'b011:  fmt_load = {16'b0, h};
      default: fmt_load = rdata;
    endcase
  endfunction

  logic        mem_acc, align_err;
  logic        exc_d;
  logic [31:0] badv_d, status_d;
  logic [30:0] cause_d;

  logic [31:0] pc_q, result_q, badv_q, status_q, held_q;
  logic [30:0] cause_q;
  logic [4:0]  rw_q;
  logic [2:0]  memop_q;
  logic        regwrite_q, memread_q, exc_q, hold_q;
  logic [31:0] fmt_data;

  // EX side: alignment check, exception record and SRAM request
  assign mem_acc   = MemRead_in | MemWrite_in;
  assign align_err = mem_acc & (MemOp_in[2] ? (result_in[1:0] != 2'b00) :
                                MemOp_in[1] ? result_in[0] : 1'b0);

  always_comb begin
    exc_d    = 1'b0;
    badv_d   = '0;
    status_d = '0;
    cause_d  = '0;
    if (Exc_in) begin
      exc_d    = 1'b1;
      badv_d   = BadVAddr_in;
      status_d = Status_in;
      cause_d  = Cause_in;
    end else if (align_err) begin
      exc_d    = 1'b1;
      badv_d   = result_in;
      status_d = EXC_STATUS;
      cause_d  = {24'b0, (MemWrite_in ? ADES_CODE : ADEL_CODE), 2'b00};
    end
  end

  // Older excepting instruction in M must block any younger store from reaching memory.
  assign data_sram_en   = mem_acc & ~align_err & ~Exc_in & ~exc_q & ~stall & ~flush & ~rst;
  assign data_sram_addr = {result_in[31:2], 2'b00} & ADDR_MASK;

  always_comb begin
    data_sram_wen   = 4'b0000;
    data_sram_wdata = D_in;
    case (MemOp_in[2:1])
      2'b00:   data_sram_wdata = {4{D_in[7:0]}};
      2'b01:   data_sram_wdata = {2{D_in[15:0]}};
      default: data_sram_wdata = D_in;
    endcase
    if (data_sram_en && MemWrite_in && !MemRead_in) begin
      case (MemOp_in[2:1])
        2'b00:   data_sram_wen = 4'b0001 << result_in[1:0];
        2'b01:   data_sram_wen = result_in[1] ? 4'b1100 : 4'b0011;
        default: data_sram_wen = 4'b1111;
      endcase
    end
  end

  // EX -> M register boundary
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pc_q       <= '0;
      result_q   <= '0;
      rw_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memop_q    <= '0;
      exc_q      <= 1'b0;
      badv_q     <= '0;
      status_q   <= '0;
      cause_q    <= '0;
    end else if (!stall) begin
      pc_q       <= PC_in;
      result_q   <= result_in;
      rw_q       <= rw_in;
      regwrite_q <= RegWrite_in;
      memread_q  <= MemRead_in;
      memop_q    <= MemOp_in;
      exc_q      <= exc_d;
      badv_q     <= badv_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
    end
  end

  // SRAM data is only valid one cycle after the request, so a stalled load keeps its own copy.
  assign fmt_data = fmt_load(data_sram_rdata, memop_q, result_q[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
      held_q <= '0;
    end else if (flush || !stall) begin
      hold_q <= 1'b0;
    end else if (memread_q && !hold_q) begin
      hold_q <= 1'b1;
      held_q <= fmt_data;
    end
  end

  assign PC_out       = pc_q;
  assign result_mem   = result_q;
  assign rw_out       = rw_q;
  assign RegWrite_out = regwrite_q & ~exc_q;
  assign Exc_mem      = exc_q;
  assign BadVAddr_out = badv_q;
  assign Status_out   = status_q;
  assign Cause_out    = cause_q;
  assign dataW        = memread_q ? (hold_q ? held_q : fmt_data) : result_q;

endmodule
